instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Single-outstanding instruction fetcher feeding a small in-order buffer
//   toward the decoder. Handles branch/jump redirects, including discarding
//   a response that was already in flight when the redirect arrived.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   imem_req/addr     fetch request and word-aligned address (held until gnt)
//   imem_gnt          memory accepted the request this cycle
//   imem_rvalid/rdata read response, one per grant, >=1 cycle after the grant
//   instr_valid/ready decoder handshake for {instruction, instr_pc}
//   redirect/_pc      one-cycle redirect strobe and target (bits [1:0] ignored)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2            // 2 or 4 (pointers wrap naturally)
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                       state, state_nxt;
  logic [31:0]                  fetch_pc, fetch_pc_nxt;
  logic [31:0]                  tag_pc, tag_pc_nxt;   // address of the outstanding request
  logic                         drop, drop_nxt;       // outstanding response is stale
  logic [PW-1:0]                wptr, rptr;
  logic [CW-1:0]                count, count_nxt;
  logic [FIFO_DEPTH-1:0][31:0]  buf_data, buf_pc;
  logic                         granted, push, pop;
  logic [31:0]                  redir_tgt;

  assign redir_tgt = {redirect_pc[31:2], 2'b00};
  assign granted   = (state == REQ) && imem_gnt;

  // Redirect wins over everything: no push of the response arriving with it,
  // no pop of the head it is flushing.
  assign push = (state == WAIT) && imem_rvalid && !drop && !redirect;
  assign pop  = instr_valid && instr_ready && !redirect;

  always_comb begin
    count_nxt = count;
    if (redirect) count_nxt = '0;
    else          count_nxt = count + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    tag_pc_nxt   = tag_pc;
    drop_nxt     = drop;
    case (state)
      IDLE: if (count < DEPTH_C) state_nxt = REQ;
      REQ: if (imem_gnt) begin
        state_nxt    = WAIT;
        tag_pc_nxt   = fetch_pc;
        fetch_pc_nxt = fetch_pc + 32'd4;     // wraps modulo 2^32
      end
      WAIT: if (imem_rvalid) begin
        drop_nxt  = 1'b0;
        // Admission check uses post-push/pop occupancy so a push never overflows.
        state_nxt = (count_nxt < DEPTH_C) ? REQ : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (redirect) begin
      fetch_pc_nxt = redir_tgt;
      if (granted || (state == WAIT && !imem_rvalid)) begin
        // A response is still owed; swallow it before issuing the new target.
        state_nxt = WAIT;
        drop_nxt  = 1'b1;
      end else begin
        state_nxt = REQ;
        drop_nxt  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      tag_pc   <= '0;
      drop     <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      tag_pc   <= tag_pc_nxt;
      drop     <= drop_nxt;
      count    <= count_nxt;
      if (redirect) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) wptr <= wptr + PW'(1);
        if (pop)  rptr <= rptr + PW'(1);
      end
    end
  end

  // Storage needs no reset: it is only observed through the valid-gated head.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wptr] <= imem_rdata;
      buf_pc[wptr]   <= tag_pc;
    end
  end

  assign imem_req    = (state == REQ);
  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != '0);
  assign instruction = instr_valid ? buf_data[rptr] : '0;
  assign instr_pc    = instr_valid ? buf_pc[rptr]   : '0;

endmodule
